// File: rtl/drop_scheduler.sv
// rtl/drop_scheduler.sv - chart walker that spawns notes into dropper slots and tallies hit/miss results
module drop_scheduler #(
    parameter int         N_SLOTS   = 8,
    parameter int         ADDR_W    = 8,
    parameter int         POINTS    = 10,
    parameter logic [7:0] START_KEY = 8'h2c,
    parameter logic [7:0] EXIT_KEY  = 8'h01
) (
    input  logic               frame_clk,
    input  logic               Reset,
    input  logic [7:0]         keycode,
    input  logic [7:0]         keycode_second,
    output logic [ADDR_W-1:0]  chart_addr,
    input  logic [15:0]        chart_time,
    input  logic [1:0]         chart_lane,
    input  logic               chart_last,
    input  logic [N_SLOTS-1:0] slot_busy,
    input  logic [N_SLOTS-1:0] slot_done,
    input  logic [N_SLOTS-1:0] slot_hit,
    output logic [N_SLOTS-1:0] spawn,
    output logic [1:0]         spawn_lane,
    output logic [15:0]        song_timer,
    output logic [15:0]        score,
    output logic [7:0]         combo,
    output logic [7:0]         max_combo,
    output logic [7:0]         dropped,
    output logic               playing,
    output logic               song_done
);
    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_DRAIN, S_DONE} state_t;

    state_t              r_state, w_state_nx;
    logic [ADDR_W-1:0]   r_addr;
    logic [N_SLOTS-1:0]  r_spawn;
    logic [1:0]          r_lane;
    logic [15:0]         r_timer, r_score;
    logic [7:0]          r_combo, r_max, r_dropped;

    function automatic logic [4:0] popcount(input logic [N_SLOTS-1:0] v);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < N_SLOTS; i++) c = c + 5'(v[i]);
        return c;
    endfunction

    logic               w_start, w_exit, w_due, w_spawn_go, w_skip;
    logic [N_SLOTS-1:0] w_free, w_pick;
    logic [4:0]         w_h, w_m;
    logic [17:0]        w_score_sum;
    logic [8:0]         w_combo_sum;
    logic [15:0]        w_score_nx, w_timer_nx;
    logic [7:0]         w_combo_nx, w_max_nx, w_dropped_nx;

    assign w_start = (keycode == START_KEY) || (keycode_second == START_KEY);
    assign w_exit  = (keycode == EXIT_KEY)  || (keycode_second == EXIT_KEY);

    // A slot spawned last frame still reads idle this frame, so r_spawn doubles as the reservation mask
    assign w_free     = ~slot_busy & ~r_spawn;
    assign w_pick     = w_free & (~w_free + N_SLOTS'(1));
    assign w_due      = (r_state == S_PLAY) && (r_timer >= chart_time);
    assign w_spawn_go = w_due && (|w_free);
    assign w_skip     = w_due && !(|w_free);

    assign w_h          = popcount(slot_done & slot_hit);
    assign w_m          = popcount(slot_done & ~slot_hit);
    assign w_score_sum  = {2'b00, r_score} + 18'(w_h) * 18'(POINTS);
    assign w_score_nx   = (|w_score_sum[17:16]) ? 16'hFFFF : w_score_sum[15:0];
    assign w_combo_sum  = {1'b0, r_combo} + 9'(w_h);
    assign w_combo_nx   = ((w_m != 5'd0) || w_skip) ? 8'd0 :
                          (w_combo_sum[8] ? 8'hFF : w_combo_sum[7:0]);
    assign w_max_nx     = (w_combo_nx > r_max) ? w_combo_nx : r_max;
    assign w_dropped_nx = (w_skip && (r_dropped != 8'hFF)) ? r_dropped + 8'd1 : r_dropped;
    assign w_timer_nx   = (r_timer == 16'hFFFF) ? r_timer : r_timer + 16'd1;

    always_ff @(posedge frame_clk) begin
        if (Reset) r_state <= S_IDLE;
        else       r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_state_nx = S_PLAY;
            S_PLAY:  if (w_due && chart_last) w_state_nx = S_DRAIN;
            S_DRAIN: if ((slot_busy == '0) && (r_spawn == '0) && (slot_done == '0))
                         w_state_nx = S_DONE;
            S_DONE:  if (w_exit) w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        playing   = (r_state == S_PLAY) || (r_state == S_DRAIN);
        song_done = (r_state == S_DONE);
    end

    // Counters are zero throughout IDLE, so the START edge needs no separate clear
    always_ff @(posedge frame_clk) begin
        if (Reset || (r_state == S_IDLE) || ((r_state == S_DONE) && w_exit)) begin
            r_addr    <= '0;
            r_spawn   <= '0;
            r_lane    <= '0;
            r_timer   <= '0;
            r_score   <= '0;
            r_combo   <= '0;
            r_max     <= '0;
            r_dropped <= '0;
        end else if (r_state != S_DONE) begin
            r_timer   <= w_timer_nx;
            r_score   <= w_score_nx;
            r_combo   <= w_combo_nx;
            r_max     <= w_max_nx;
            r_dropped <= w_dropped_nx;
            r_spawn   <= w_spawn_go ? w_pick : '0;
            r_lane    <= w_spawn_go ? chart_lane : 2'd0;
            if (w_due && !chart_last) r_addr <= r_addr + ADDR_W'(1);
        end
    end

    assign chart_addr = r_addr;
    assign spawn      = r_spawn;
    assign spawn_lane = r_lane;
    assign song_timer = r_timer;
    assign score      = r_score;
    assign combo      = r_combo;
    assign max_combo  = r_max;
    assign dropped    = r_dropped;
endmodule

// File: tb/tb_drop_scheduler.sv
// tb/tb_drop_scheduler.sv - directed self-checking bench for drop_scheduler
module tb_drop_scheduler;
    localparam logic [7:0] START_KEY = 8'h2c;
    localparam logic [7:0] EXIT_KEY  = 8'h01;

    logic        frame_clk, Reset;
    logic [7:0]  keycode, keycode_second;
    logic [7:0]  chart_addr;
    logic [15:0] chart_time;
    logic [1:0]  chart_lane;
    logic        chart_last;
    logic [7:0]  slot_busy, slot_done, slot_hit, spawn;
    logic [1:0]  spawn_lane;
    logic [15:0] song_timer, score;
    logic [7:0]  combo, max_combo, dropped;
    logic        playing, song_done;

    logic [15:0] rom_time [256];
    logic [1:0]  rom_lane [256];
    logic        rom_last [256];

    int n_chk  = 0;
    int n_fail = 0;

    assign chart_time = rom_time[chart_addr];
    assign chart_lane = rom_lane[chart_addr];
    assign chart_last = rom_last[chart_addr];

    drop_scheduler dut (
        .frame_clk(frame_clk), .Reset(Reset),
        .keycode(keycode), .keycode_second(keycode_second),
        .chart_addr(chart_addr), .chart_time(chart_time),
        .chart_lane(chart_lane), .chart_last(chart_last),
        .slot_busy(slot_busy), .slot_done(slot_done), .slot_hit(slot_hit),
        .spawn(spawn), .spawn_lane(spawn_lane), .song_timer(song_timer),
        .score(score), .combo(combo), .max_combo(max_combo), .dropped(dropped),
        .playing(playing), .song_done(song_done)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_done(input logic [7:0] d, input logic [7:0] h);
        slot_done = d;
        slot_hit  = h;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            rom_time[i] = 16'hFFFF;
            rom_lane[i] = 2'd0;
            rom_last[i] = 1'b1;
        end
        Reset = 1'b1; keycode = 8'h00; keycode_second = 8'h00;
        slot_busy = 8'h00; set_done(8'h00, 8'h00);
        tick(); tick();
        chk("rst_playing", playing, 0);
        chk("rst_done", song_done, 0);
        chk("rst_addr", chart_addr, 0);
        chk("rst_spawn", spawn, 0);
        chk("rst_score", score, 0);
        chk("rst_timer", song_timer, 0);
        Reset = 1'b0;

        // Song A: two tied notes at t=5, then drain and exit
        rom_time[0] = 16'd5; rom_lane[0] = 2'd1; rom_last[0] = 1'b0;
        rom_time[1] = 16'd5; rom_lane[1] = 2'd2; rom_last[1] = 1'b1;
        keycode_second = START_KEY;
        tick();
        keycode_second = 8'h00;
        chk("a_playing", playing, 1);
        chk("a_timer0", song_timer, 0);
        for (int i = 0; i < 5; i++) tick();
        chk("a_timer5", song_timer, 5);
        chk("a_nospawn", spawn, 0);
        tick();
        chk("a_spawn0", spawn, 8'h01);
        chk("a_lane0", spawn_lane, 1);
        chk("a_addr1", chart_addr, 1);
        tick();
        chk("a_spawn1", spawn, 8'h02);
        chk("a_lane1", spawn_lane, 2);
        chk("a_addr_hold", chart_addr, 1);
        chk("a_timer7", song_timer, 7);
        slot_busy = 8'h03;
        tick();
        chk("a_drain_nospawn", spawn, 0);
        chk("a_drain_playing", playing, 1);
        chk("a_drain_timer", song_timer, 8);
        slot_busy = 8'h02; set_done(8'h01, 8'h01);
        tick();
        chk("a_score10", score, 10);
        chk("a_combo1", combo, 1);
        slot_busy = 8'h00; set_done(8'h02, 8'h02);
        tick();
        chk("a_score20", score, 20);
        chk("a_max2", max_combo, 2);
        chk("a_pending_done", song_done, 0);
        set_done(8'h00, 8'h00);
        tick();
        chk("a_song_done", song_done, 1);
        chk("a_done_playing", playing, 0);
        chk("a_done_timer", song_timer, 11);
        set_done(8'h01, 8'h01);
        tick();
        chk("a_frozen_score", score, 20);
        chk("a_frozen_timer", song_timer, 11);
        set_done(8'h00, 8'h00);
        keycode = EXIT_KEY;
        tick();
        keycode = 8'h00;
        chk("a_exit_done", song_done, 0);
        chk("a_exit_score", score, 0);
        chk("a_exit_timer", song_timer, 0);
        chk("a_exit_max", max_combo, 0);
        chk("a_exit_addr", chart_addr, 0);

        // Song B: skip with all slots busy, mixed results, then reset on a due spawn
        rom_time[0] = 16'd3;  rom_lane[0] = 2'd0; rom_last[0] = 1'b0;
        rom_time[1] = 16'd10; rom_lane[1] = 2'd3; rom_last[1] = 1'b1;
        slot_busy = 8'hFF;
        keycode = START_KEY;
        tick();
        keycode = 8'h00;
        set_done(8'h01, 8'h01);
        tick();
        chk("b_combo1", combo, 1);
        set_done(8'h00, 8'h00);
        tick(); tick();
        chk("b_timer3", song_timer, 3);
        tick();
        chk("b_skip_spawn", spawn, 0);
        chk("b_dropped", dropped, 1);
        chk("b_skip_combo", combo, 0);
        chk("b_skip_max", max_combo, 1);
        chk("b_skip_addr", chart_addr, 1);
        set_done(8'h0F, 8'h0F);
        tick();
        chk("b_combo4", combo, 4);
        chk("b_score50", score, 50);
        set_done(8'h07, 8'h03);
        tick();
        chk("b_mix_score", score, 70);
        chk("b_mix_combo", combo, 0);
        chk("b_mix_max", max_combo, 4);
        set_done(8'h01, 8'h01);
        tick();
        chk("b_rehit_combo", combo, 1);
        chk("b_rehit_score", score, 80);
        set_done(8'h00, 8'h00);
        slot_busy = 8'h00;
        tick(); tick(); tick();
        chk("b_due_timer", song_timer, 10);
        chk("b_due_nospawn", spawn, 0);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("b_rst_spawn", spawn, 0);
        chk("b_rst_playing", playing, 0);
        chk("b_rst_score", score, 0);
        chk("b_rst_addr", chart_addr, 0);
        chk("b_rst_dropped", dropped, 0);

        // Song C: 260 single hits saturate the combo
        rom_time[0] = 16'd1000; rom_last[0] = 1'b1;
        slot_busy = 8'hFF;
        keycode = START_KEY;
        tick();
        keycode = 8'h00;
        set_done(8'h01, 8'h01);
        for (int i = 0; i < 260; i++) tick();
        set_done(8'h00, 8'h00);
        chk("c_combo_sat", combo, 255);
        chk("c_max_sat", max_combo, 255);
        chk("c_score", score, 2600);
        chk("c_timer", song_timer, 260);
        chk("c_dropped", dropped, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
